// File: rtl/fir_mac_engine.sv
// fir_mac_engine: sequential 11-tap FIR built on two bram11 ports.
// One BRAM holds the coefficients (read-only here). The other BRAM is an
// 11-entry sample ring: it is zeroed at start, and each new sample overwrites
// the oldest entry.
// Each sample accepted on ss_* is written into the ring, then 11 pipelined
// tap/sample reads are multiply-accumulated, and the result is offered on sm_*.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   start, data_length       run control; data_length is latched at start
//   busy, done               run status; done is a one-cycle pulse
//   ss_tvalid/tdata/tready   input sample stream
//   sm_tvalid/tdata/tready   output sample stream
//   tap_*                    coefficient BRAM port (read only)
//   data_*                   sample ring BRAM port
// Optional build macro FIR_SAT_EN: when it is defined, the product and every
// accumulate saturate to the signed range. When it is undefined, the
// arithmetic wraps modulo 2^DATA_WIDTH.
module fir_mac_engine #(
  parameter int unsigned NUM_TAP    = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [31:0]           data_length,
  output logic                  busy,
  output logic                  done,
  input  logic                  ss_tvalid,
  input  logic [DATA_WIDTH-1:0] ss_tdata,
  output logic                  ss_tready,
  output logic                  sm_tvalid,
  output logic [DATA_WIDTH-1:0] sm_tdata,
  input  logic                  sm_tready,
  output logic                  tap_EN,
  output logic [3:0]            tap_WE,
  output logic [ADDR_WIDTH-1:0] tap_A,
  output logic [DATA_WIDTH-1:0] tap_Di,
  input  logic [DATA_WIDTH-1:0] tap_Do,
  output logic                  data_EN,
  output logic [3:0]            data_WE,
  output logic [ADDR_WIDTH-1:0] data_A,
  output logic [DATA_WIDTH-1:0] data_Di,
  input  logic [DATA_WIDTH-1:0] data_Do
);

  // k must reach NUM_TAP: there is one extra drain cycle for the read latency.
  localparam int unsigned K_W = $clog2(NUM_TAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_WRITE,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t                  state;
  logic [K_W-1:0]          ptr;
  logic [K_W-1:0]          k;
  logic [31:0]             len;
  logic [31:0]             cnt;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   acc_next;

  // The coefficient BRAM is never written from here.
  assign tap_WE = 4'b0000;
  assign tap_Di = '0;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [K_W-1:0] idx);
    return ADDR_WIDTH'(idx) << 2;
  endfunction

  // Computes (p - d) mod NUM_TAP for p, d < NUM_TAP. Any wrap in the
  // intermediate K_W-bit result cancels out.
  function automatic logic [K_W-1:0] ring_idx(input logic [K_W-1:0] p,
                                              input logic [K_W-1:0] d);
    if (p >= d) return p - d;
    else        return p + K_W'(NUM_TAP) - d;
  endfunction

`ifdef FIR_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [2*DATA_WIDTH-1:0] prod_full;
  logic [DATA_WIDTH-1:0]          prod_term;
  logic [DATA_WIDTH:0]            sum_ext;

  // Saturating multiply-accumulate: clamp the product, then clamp the sum.
  always_comb begin
    prod_full = $signed(tap_Do) * $signed(data_Do);
    if ((&prod_full[2*DATA_WIDTH-1:DATA_WIDTH-1]) ||
        (~|prod_full[2*DATA_WIDTH-1:DATA_WIDTH-1]))
      prod_term = prod_full[DATA_WIDTH-1:0];
    else
      prod_term = prod_full[2*DATA_WIDTH-1] ? SAT_MIN : SAT_MAX;
    sum_ext = {acc[DATA_WIDTH-1], acc} + {prod_term[DATA_WIDTH-1], prod_term};
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1])
      acc_next = sum_ext[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    else
      acc_next = sum_ext[DATA_WIDTH-1:0];
  end
`else
  // Wrapping multiply-accumulate. Only the low product bits matter, so the
  // signedness of the operands does not change the result.
  always_comb begin
    acc_next = acc + tap_Do * data_Do;
  end
`endif

  // Control FSM with registered outputs and BRAM port drive.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ss_tready <= 1'b0;
      sm_tvalid <= 1'b0;
      sm_tdata  <= '0;
      ptr       <= '0;
      k         <= '0;
      len       <= '0;
      cnt       <= '0;
      acc       <= '0;
      tap_EN    <= 1'b0;
      tap_A     <= '0;
      data_EN   <= 1'b0;
      data_WE   <= 4'b0000;
      data_A    <= '0;
      data_Di   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len  <= data_length;
            cnt  <= '0;
            busy <= 1'b1;
            if (data_length == 32'd0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              k       <= '0;
              data_EN <= 1'b1;
              data_WE <= 4'b1111;
              data_A  <= '0;
              data_Di <= '0;
              state   <= S_CLEAR;
            end
          end
        end

        // Zero every ring entry so that samples from an earlier run cannot leak.
        S_CLEAR: begin
          if (k == K_W'(NUM_TAP - 1)) begin
            data_EN   <= 1'b0;
            data_WE   <= 4'b0000;
            data_A    <= '0;
            ptr       <= '0;
            ss_tready <= 1'b1;
            state     <= S_WAIT_IN;
          end else begin
            k      <= k + K_W'(1);
            data_A <= addr_of(k + K_W'(1));
          end
        end

        S_WAIT_IN: begin
          if (ss_tvalid && ss_tready) begin
            ss_tready <= 1'b0;
            data_EN   <= 1'b1;
            data_WE   <= 4'b1111;
            data_A    <= addr_of(ptr);
            data_Di   <= ss_tdata;
            state     <= S_WRITE;
          end
        end

        // The write lands this cycle. Set up the k=0 read: newest sample and tap 0.
        S_WRITE: begin
          acc     <= '0;
          k       <= '0;
          data_WE <= 4'b0000;
          data_Di <= '0;
          data_A  <= addr_of(ptr);
          tap_EN  <= 1'b1;
          tap_A   <= '0;
          state   <= S_MAC;
        end

        // The read issued in cycle k returns in cycle k+1, so the accumulate
        // lags the address by one cycle.
        S_MAC: begin
          if (k != '0) acc <= acc_next;
          if (k == K_W'(NUM_TAP)) begin
            sm_tdata  <= acc_next;
            sm_tvalid <= 1'b1;
            state     <= S_OUT;
          end else begin
            k <= k + K_W'(1);
            if (k == K_W'(NUM_TAP - 1)) begin
              tap_EN  <= 1'b0;
              tap_A   <= '0;
              data_EN <= 1'b0;
              data_A  <= '0;
            end else begin
              tap_A  <= addr_of(k + K_W'(1));
              data_A <= addr_of(ring_idx(ptr, k + K_W'(1)));
            end
          end
        end

        S_OUT: begin
          if (sm_tready) begin
            sm_tvalid <= 1'b0;
            ptr       <= (ptr == K_W'(NUM_TAP - 1)) ? '0 : ptr + K_W'(1);
            cnt       <= cnt + 32'd1;
            if (cnt + 32'd1 == len) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              ss_tready <= 1'b1;
              state     <= S_WAIT_IN;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Scoreboard testbench for fir_mac_engine.
// It models both BRAMs and computes each expected output as a direct FIR sum
// over the sample history of the current run.
module tb_fir_mac_engine;
  localparam int NT = 11;
  localparam int DW = 32;
  localparam int AW = 12;

  logic          CLK = 1'b0;
  logic          RST, start;
  logic [31:0]   data_length;
  logic          busy, done;
  logic          ss_tvalid, ss_tready;
  logic [DW-1:0] ss_tdata;
  logic          sm_tvalid, sm_tready;
  logic [DW-1:0] sm_tdata;
  logic          tap_EN, data_EN;
  logic [3:0]    tap_WE, data_WE;
  logic [AW-1:0] tap_A, data_A;
  logic [DW-1:0] tap_Di, tap_Do, data_Di, data_Do;

  always #5 CLK = ~CLK;

  fir_mac_engine #(.NUM_TAP(NT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .data_length(data_length),
    .busy(busy), .done(done),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tready(sm_tready),
    .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do),
    .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di),
    .data_Do(data_Do)
  );

  // BRAM models: byte write enables, registered read data, old value on read.
  logic [DW-1:0] tap_mem [NT];
  logic [DW-1:0] data_mem[NT];
  int            data_wr_cnt = 0;

  always @(posedge CLK) begin
    int ti;
    int di;
    ti = int'(tap_A >> 2);
    di = int'(data_A >> 2);
    if (tap_EN && ti < NT) tap_Do <= tap_mem[ti];
    if (data_EN && di < NT) begin
      data_Do <= data_mem[di];
      for (int b = 0; b < 4; b++)
        if (data_WE[b]) data_mem[di][8*b +: 8] <= data_Di[8*b +: 8];
    end
    if (data_EN && (|data_WE)) data_wr_cnt <= data_wr_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit hold = 1'b0;
  bit rand_ready = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] got[$];
  logic [31:0] hist[$];
  logic [31:0] stim[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One multiply-accumulate step, written from the arithmetic rules.
  function automatic logic [31:0] mac_step(input logic [31:0] acc, input logic [31:0] h,
                                           input logic [31:0] x);
`ifdef FIR_SAT_EN
    longint p, s;
    p = longint'($signed(h)) * longint'($signed(x));
    if (p > 64'sd2147483647) p = 64'sd2147483647;
    else if (p < -64'sd2147483648) p = -64'sd2147483648;
    s = longint'($signed(acc)) + p;
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
    return 32'(s);
`else
    return acc + h * x;
`endif
  endfunction

  // y[n] = sum over i of h[i] * x[n-i], where x before the run start is zero.
  function automatic logic [31:0] model_y();
    logic [31:0] acc = 32'd0;
    int n = hist.size() - 1;
    for (int i = 0; i < NT; i++)
      acc = mac_step(acc, tap_mem[i], (n - i >= 0) ? hist[n - i] : 32'd0);
    return acc;
  endfunction

  // Output monitor: pops and compares on every output handshake.
  always @(negedge CLK) begin
    if (!RST && sm_tvalid && sm_tready) begin
      got.push_back(sm_tdata);
      if (sb.size() == 0) check("unexpected_output", 64'(sm_tdata), 64'hDEAD_0000_0000);
      else check("sm_tdata", 64'(sm_tdata), 64'(sb.pop_front()));
    end
    if (done) done_cnt++;
  end

  // Consumer-ready driver.
  initial begin
    sm_tready = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (hold) sm_tready = 1'b0;
      else if (rand_ready) sm_tready = ($urandom_range(0, 3) != 0);
      else sm_tready = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, 64'({busy, done, ss_tready, sm_tvalid}), 64'd0);
    check({tag, "_sm_tdata"}, 64'(sm_tdata), 64'd0);
    check({tag, "_bram"}, 64'({tap_EN, tap_WE, tap_A, data_EN, data_WE, data_A}), 64'd0);
    check({tag, "_di"}, 64'(tap_Di | data_Di), 64'd0);
  endtask

  task automatic do_start(input int len, input bit dup);
    data_length = 32'(len);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    hist.delete();
    // This second start arrives while busy and must be ignored.
    if (dup) begin
      data_length = 32'd1;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] x, input bit push, input bit meas, input bit bp);
    int n = 0;
    int lat = 0;
    int wr0;
    logic [31:0] d;
    ss_tvalid = 1'b1;
    ss_tdata  = x;
    forever begin
      @(negedge CLK);
      if (ss_tready) break;
      n++;
      if (n > 300) begin
        check("ss_tready_timeout", 64'd0, 64'd1);
        ss_tvalid = 1'b0;
        return;
      end
    end
    @(posedge CLK); #1;
    ss_tvalid = 1'b0;
    ss_tdata  = $urandom;
    if (push) begin
      hist.push_back(x);
      sb.push_back(model_y());
    end
    if (meas) begin
      while (!sm_tvalid && lat < 40) begin
        @(posedge CLK); #1;
        lat++;
      end
      check("latency", 64'(lat), 64'd13);
    end
    if (bp) begin
      d   = sm_tdata;
      wr0 = data_wr_cnt;
      for (int c = 0; c < 20; c++) begin
        @(negedge CLK);
        check("bp_stable", 64'({sm_tvalid, ss_tready, tap_EN & (|tap_WE), sm_tdata}),
              64'({1'b1, 1'b0, 1'b0, d}));
      end
      check("bp_no_writes", 64'(data_wr_cnt - wr0), 64'd0);
      hold = 1'b0;
    end
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("busy_low", 64'(busy), 64'd0);
    @(posedge CLK); #1;
  endtask

  task automatic run_job(input int len, input bit meas, input bit dup);
    int d0 = done_cnt;
    got.delete();
    do_start(len, dup);
    for (int i = 0; i < len; i++) send(stim[i], 1'b1, meas, 1'b0);
    wait_done(d0);
    check("out_count", 64'(got.size()), 64'(len));
  endtask

  initial begin
    int d0;
    RST = 1'b1; start = 1'b0; data_length = '0; ss_tvalid = 1'b0; ss_tdata = '0;
    for (int i = 0; i < NT; i++) begin
      tap_mem[i]  = '0;
      data_mem[i] = $urandom;
    end
    repeat (3) @(posedge CLK); #1;
    check_reset_vals("reset");
    RST = 1'b0;
    @(posedge CLK); #1;

    // Impulse response reproduces the taps.
    for (int i = 0; i < NT; i++) tap_mem[i] = 32'(i + 1);
    stim.delete();
    stim.push_back(32'd1);
    for (int i = 1; i < 11; i++) stim.push_back(32'd0);
    run_job(11, 1'b1, 1'b0);
    for (int i = 0; i < 11 && i < got.size(); i++) check("impulse", 64'(got[i]), 64'(i + 1));

    // Ring wrap with all-ones taps, plus a start pulse while busy.
    rand_ready = 1'b1;
    for (int i = 0; i < NT; i++) tap_mem[i] = 32'd1;
    stim.delete();
    for (int i = 0; i < 25; i++) stim.push_back(32'(i + 1));
    run_job(25, 1'b0, 1'b1);
    if (got.size() == 25) begin
      check("wrap_y0", 64'(got[0]), 64'd1);
      check("wrap_y10", 64'(got[10]), 64'd66);
      check("wrap_y11", 64'(got[11]), 64'd77);
      check("wrap_y24", 64'(got[24]), 64'd220);
    end

    // Backpressure on output 0.
    d0 = done_cnt;
    got.delete();
    do_start(2, 1'b0);
    hold = 1'b1;
    send(32'd4, 1'b1, 1'b1, 1'b1);
    send(32'd9, 1'b1, 1'b0, 1'b0);
    wait_done(d0);

    // A restart must not see stale ring data.
    stim.delete();
    for (int i = 0; i < 11; i++) stim.push_back(32'd5);
    run_job(11, 1'b0, 1'b0);
    stim.delete();
    stim.push_back(32'd1);
    run_job(1, 1'b0, 1'b0);
    if (got.size() == 1) check("restart_y0", 64'(got[0]), 64'd1);

    // Reset in MAC cycle k=6 aborts the run without a done pulse.
    d0 = done_cnt;
    do_start(5, 1'b0);
    send(32'd9, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    check_reset_vals("midmac");
    RST = 1'b0;
    repeat (20) @(posedge CLK); #1;
    check("midmac_no_done", 64'(done_cnt - d0), 64'd0);
    sb.delete();
    for (int i = 0; i < NT; i++) tap_mem[i] = $urandom;
    tap_mem[0] = 32'd3;
    stim.delete();
    stim.push_back(32'd7);
    run_job(1, 1'b1, 1'b0);
    if (got.size() == 1) check("after_reset_y", 64'(got[0]), 64'd21);

    // A zero-length run goes straight to done.
    run_job(0, 1'b0, 1'b0);

    // Overflow of a single product.
    tap_mem[0] = 32'h4000_0000;
    stim.delete();
    stim.push_back(32'h4000_0000);
    run_job(1, 1'b0, 1'b0);
`ifdef FIR_SAT_EN
    if (got.size() == 1) check("overflow_y", 64'(got[0]), 64'h7FFF_FFFF);
`else
    if (got.size() == 1) check("overflow_y", 64'(got[0]), 64'h0);
`endif

    // Randomized runs.
    for (int r = 0; r < 5; r++) begin
      int len = $urandom_range(1, 20);
      for (int i = 0; i < NT; i++)
        tap_mem[i] = (r < 2) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
      stim.delete();
      for (int i = 0; i < len; i++)
        stim.push_back((r < 2) ? 32'($signed($urandom_range(0, 2000)) - 1000) : $urandom);
      run_job(len, (r == 0), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
